// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch FSM state encoding
//   - stop opcode and execution-unit opcode values
//   - field-slice helpers for the 32-bit instruction layout
//     [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [7:0] STOP_OPC      = 8'hFF;
  localparam logic [7:0] OPC_ADD       = 8'h00;
  localparam logic [7:0] OPC_SUB       = 8'h01;
  localparam logic [7:0] OPC_TRANSPOSE = 8'h02;
  localparam logic [7:0] OPC_SCALE     = 8'h03;
  localparam logic [7:0] OPC_MULT      = 8'h04;

  function automatic logic [7:0] instr_opcode(input logic [31:0] instr);
    return instr[31:24];
  endfunction

  function automatic logic [7:0] instr_dest(input logic [31:0] instr);
    return instr[23:16];
  endfunction

  function automatic logic [7:0] instr_src1(input logic [31:0] instr);
    return instr[15:8];
  endfunction

  function automatic logic [7:0] instr_src2(input logic [31:0] instr);
    return instr[7:0];
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction RAM: synchronous write, synchronous read.
// The read data register doubles as the fetch unit's instruction output, so
// it is cleared by reset and holds its value whenever re is low. Memory
// contents are never reset.
//   clk, reset      : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read enable and address
//   rdata           : registered read data
module imem_array #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with program counter and valid/ready output.
// A program is written over the ld* port while not running; start launches a
// fetch stream from startPc. The run ends in DONE when the stop word is
// accepted, or in FAULT when the word at DEPTH-1 is accepted without a stop.
//   clk, reset                  : clock, synchronous active-high reset
//   ldEn/ldAddr/ldData          : program load (ignored in RUN)
//   start/startPc               : launch a run (IDLE/DONE/FAULT only)
//   abort                       : return to IDLE from any state
//   instrValid/instrReady       : output handshake
//   instrOut/instrPc            : presented word and its address
//   busy/done/fault             : registered state decodes
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 16,
  parameter int               ADDR_W   = $clog2(DEPTH),
  parameter int               OPC_W    = 8,
  parameter logic [OPC_W-1:0] STOP_OPC = imem_pkg::STOP_OPC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ldEn,
  input  logic [ADDR_W-1:0]  ldAddr,
  input  logic [INSTR_W-1:0] ldData,
  input  logic               start,
  input  logic [ADDR_W-1:0]  startPc,
  input  logic               abort,
  input  logic               instrReady,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instrOut,
  output logic [ADDR_W-1:0]  instrPc,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              valid_d, valid_q;
  logic              stop_seen_d, stop_seen_q;
  logic              end_seen_d, end_seen_q;
  logic              busy_d, busy_q, done_d, done_q, fault_d, fault_q;

  logic              adv, accept, stop_seen, end_seen, fetch, mem_we;
  logic [INSTR_W-1:0] rdata;

  imem_array #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .waddr(ldAddr),
    .wdata(ldData),
    .re   (fetch),
    .raddr(rd_addr_q),
    .rdata(rdata)
  );

  always_comb begin
    adv    = !valid_q || instrReady;
    accept = valid_q && instrReady;
    mem_we = ldEn && (state_q != RUN);
    // The RAM read is synchronous, so the opcode of a fetched word is only
    // visible one cycle later on the output register; the stop flag merges
    // the sticky register with the word currently presented.
    stop_seen = stop_seen_q || (valid_q && (rdata[INSTR_W-1 -: OPC_W] == STOP_OPC));
    // end_seen_q marks that the last address has been fetched; it only means
    // "ran off the end" when that word was not itself a stop.
    end_seen  = end_seen_q && !stop_seen;
    // Read enable is the advance condition gated by run state and exit
    // conditions, so the output register holds when nothing is fetched.
    fetch = (state_q == RUN) && adv && !stop_seen && !end_seen_q && !abort;

    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stop_seen_d = stop_seen_q;
    end_seen_d  = end_seen_q;

    case (state_q)
      RUN: begin
        stop_seen_d = stop_seen;
        if (accept && stop_seen) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else if (accept && end_seen) begin
          state_d = FAULT;
          valid_d = 1'b0;
        end else if (fetch) begin
          valid_d = 1'b1;
          pc_d    = rd_addr_q;
          // Hold at the last address instead of wrapping.
          if (rd_addr_q == LAST) end_seen_d = 1'b1;
          else                   rd_addr_d  = rd_addr_q + ADDR_W'(1);
        end else if (adv) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        if (start) begin
          state_d     = RUN;
          rd_addr_d   = startPc;
          stop_seen_d = 1'b0;
          end_seen_d  = 1'b0;
          valid_d     = 1'b0;
        end
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      valid_d     = 1'b0;
      stop_seen_d = 1'b0;
      end_seen_d  = 1'b0;
    end

    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stop_seen_q <= 1'b0;
      end_seen_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stop_seen_q <= stop_seen_d;
      end_seen_q  <= end_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign instrValid = valid_q;
  assign instrOut   = rdata;
  assign instrPc    = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a 16-deep instance for the main
// program tests and a 4-deep instance for the run-off-the-end fault case.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ldEn, start, abort, instrReady;
  logic [3:0]  ldAddr, startPc, instrPc;
  logic [31:0] ldData, instrOut;
  logic        instrValid, busy, done, fault;

  logic        f_ldEn, f_start, f_abort, f_ready;
  logic [1:0]  f_ldAddr, f_startPc, f_pc;
  logic [31:0] f_ldData, f_out;
  logic        f_valid, f_busy, f_done, f_fault;

  always #5 clk = ~clk;

  imem_fetch_unit #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .ldEn(ldEn), .ldAddr(ldAddr), .ldData(ldData),
    .start(start), .startPc(startPc), .abort(abort), .instrReady(instrReady),
    .instrValid(instrValid), .instrOut(instrOut), .instrPc(instrPc),
    .busy(busy), .done(done), .fault(fault)
  );

  imem_fetch_unit #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .ldEn(f_ldEn), .ldAddr(f_ldAddr), .ldData(f_ldData),
    .start(f_start), .startPc(f_startPc), .abort(f_abort), .instrReady(f_ready),
    .instrValid(f_valid), .instrOut(f_out), .instrPc(f_pc),
    .busy(f_busy), .done(f_done), .fault(f_fault)
  );

  typedef struct packed {
    logic [3:0]  pc;
    logic [31:0] w;
  } exp_t;

  exp_t q[$];
  exp_t fq[$];
  exp_t mon_e, fmon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc = pc;
    e.w  = w;
    q.push_back(e);
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ldEn = 1'b1; ldAddr = a; ldData = d;
    tick();
    ldEn = 1'b0;
  endtask

  task automatic go(input logic [3:0] pc);
    start = 1'b1; startPc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || fault) && n < 60) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  // Monitors: pop and compare on every handshake.
  always @(negedge clk) begin
    if (!reset && instrValid && instrReady) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_word: got pc %0d instr %h, required no word", instrPc, instrOut);
      end else begin
        mon_e = q.pop_front();
        check("word_pc", 32'(instrPc), 32'(mon_e.pc));
        check("word_instr", instrOut, mon_e.w);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && f_valid && f_ready) begin
      if (fq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d4_unexpected_word: got pc %0d instr %h, required no word", f_pc, f_out);
      end else begin
        fmon_e = fq.pop_front();
        check("d4_pc", 32'(f_pc), 32'(fmon_e.pc));
        check("d4_instr", f_out, fmon_e.w);
      end
    end
  end

  initial begin
    reset = 1'b1; ldEn = 0; ldAddr = 0; ldData = 0; start = 0; startPc = 0;
    abort = 0; instrReady = 0;
    f_ldEn = 0; f_ldAddr = 0; f_ldData = 0; f_start = 0; f_startPc = 0;
    f_abort = 0; f_ready = 1'b1;
    repeat (3) tick();

    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_out",   instrOut,        32'd0);
    check("rst_pc",    32'(instrPc),    32'd0);
    check("rst_flags", {29'd0, busy, done, fault}, 32'd0);
    reset = 1'b0;

    load(4'd0, 32'h00020001);
    load(4'd1, 32'h01030200);
    load(4'd2, 32'hFFFFFFFF);
    load(4'd3, 32'h03010200);
    load(4'd4, 32'hFFFFFFFF);
    load(4'd5, 32'h04050607);
    load(4'd6, 32'hFFFFFFFF);

    // Basic run: two-cycle start latency, one word per cycle, done after stop.
    instrReady = 1'b1;
    push(0, 32'h00020001); push(1, 32'h01030200); push(2, 32'hFFFFFFFF);
    go(4'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_lat1", 32'(instrValid), 32'd0);
    tick();
    check("t1_valid_lat2", 32'(instrValid), 32'd1);
    check("t1_pc0", 32'(instrPc), 32'd0);
    tick();
    check("t1_pc1", 32'(instrPc), 32'd1);
    tick();
    check("t1_pc2", 32'(instrPc), 32'd2);
    check("t1_done_early", 32'(done), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_valid_off", 32'(instrValid), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t1_done_sticky", 32'(done), 32'd1);
    check("t1_drained", 32'(q.size()), 32'd0);

    // Stall on the second word with ready 1,0,0,1.
    push(0, 32'h00020001); push(1, 32'h01030200); push(2, 32'hFFFFFFFF);
    go(4'd0);
    tick();
    tick();
    instrReady = 1'b0;
    check("t2_stall_out0", instrOut, 32'h01030200);
    tick();
    check("t2_stall_out1", instrOut, 32'h01030200);
    check("t2_stall_pc1", 32'(instrPc), 32'd1);
    tick();
    check("t2_stall_out2", instrOut, 32'h01030200);
    check("t2_stall_valid", 32'(instrValid), 32'd1);
    instrReady = 1'b1;
    tick();
    check("t2_after_pc", 32'(instrPc), 32'd2);
    wait_end("t2");

    // Stalled run: ldEn during RUN is ignored, then abort.
    instrReady = 1'b0;
    go(4'd0);
    tick();
    check("t3_valid", 32'(instrValid), 32'd1);
    load(4'd1, 32'hDEADBEEF);
    check("t3_hold", instrOut, 32'h00020001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_valid", 32'(instrValid), 32'd0);
    check("t3_abort_idle", {29'd0, busy, done, fault}, 32'd0);

    // Restart from address 3 after the abort.
    instrReady = 1'b1;
    push(3, 32'h03010200); push(4, 32'hFFFFFFFF);
    go(4'd3);
    tick();
    check("t4_first_pc", 32'(instrPc), 32'd3);
    wait_end("t4");

    // Re-run from 0: address 1 must still hold the original word.
    push(0, 32'h00020001); push(1, 32'h01030200); push(2, 32'hFFFFFFFF);
    go(4'd0);
    wait_end("t5");

    // Write and start on the same address in the same cycle.
    push(5, 32'h020402FF); push(6, 32'hFFFFFFFF);
    ldEn = 1'b1; ldAddr = 4'd5; ldData = 32'h020402FF;
    start = 1'b1; startPc = 4'd5;
    tick();
    ldEn = 1'b0; start = 1'b0;
    tick();
    check("t6_first", instrOut, 32'h020402FF);
    wait_end("t6");

    // Reset mid-run, then a clean restart with memory intact.
    instrReady = 1'b0;
    go(4'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t7_rst_valid", 32'(instrValid), 32'd0);
    check("t7_rst_out",   instrOut,        32'd0);
    check("t7_rst_pc",    32'(instrPc),    32'd0);
    check("t7_rst_flags", {29'd0, busy, done, fault}, 32'd0);
    reset = 1'b0;
    instrReady = 1'b1;
    push(0, 32'h00020001); push(1, 32'h01030200); push(2, 32'hFFFFFFFF);
    go(4'd0);
    wait_end("t7");

    // DEPTH=4 without a stop word: four words then FAULT, no wrap.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      f_ldEn = 1'b1; f_ldAddr = 2'(i); f_ldData = 32'h00010203 + 32'(i) * 32'h01010101;
      e.pc = 4'(i);
      e.w  = 32'h00010203 + 32'(i) * 32'h01010101;
      fq.push_back(e);
      tick();
    end
    f_ldEn = 1'b0;
    f_start = 1'b1; f_startPc = 2'd0;
    tick();
    f_start = 1'b0;
    repeat (4) tick();
    check("d4_last_pc", 32'(f_pc), 32'd3);
    check("d4_no_fault_yet", 32'(f_fault), 32'd0);
    tick();
    check("d4_fault", 32'(f_fault), 32'd1);
    check("d4_valid_off", 32'(f_valid), 32'd0);
    repeat (3) tick();
    check("d4_fault_sticky", 32'(f_fault), 32'd1);
    check("d4_pc_hold", 32'(f_pc), 32'd3);
    check("d4_drained", 32'(fq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
